i2c_master: RTL and testbench

- Byte-level I2C master engine, responder side of the `i2c_transaction_*` request interface driven by ADC and sensor sequencer FSMs.
- Accepts one request: slave address, direction, byte count and write bytes. Executes it on open-drain SCL/SDA as START, address+R/W, data bytes, STOP.
- Returns read bytes and pulses done.

---
 rtl/i2c_master.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_i2c_master.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master.sv
// i2c_master: byte-level I2C master engine (START, address+R/W, data bytes, STOP)
// on open-drain SCL/SDA, serving the i2c_transaction_* request interface.
// Optional feature macro: I2C_CLOCK_STRETCH_EN (slave may hold SCL low at Q1).
module i2c_master #(
  parameter int unsigned MAX_BYTES_PER_TRANSACTION = 3,
  parameter int unsigned CLK_FREQ_HZ               = 125_000_000,
  parameter int unsigned I2C_FREQ_HZ               = 400_000
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               i2c_transaction_start,
  input  logic                                               i2c_transaction_rd_nwr,
  input  logic [6:0]                                         i2c_transaction_slave_addr,
  input  logic [$clog2(MAX_BYTES_PER_TRANSACTION+1)-1:0]     i2c_transaction_bytes_num,
  input  logic [7:0]                                         i2c_master_din  [0:MAX_BYTES_PER_TRANSACTION-1],
  output logic [7:0]                                         i2c_master_dout [0:MAX_BYTES_PER_TRANSACTION-1],
  output logic                                               i2c_transaction_done,
  output logic                                               i2c_transaction_busy,
  output logic                                               i2c_transaction_ack_error,
  input  logic                                               scl_i,
  output logic                                               scl_oe,
  input  logic                                               sda_i,
  output logic                                               sda_oe
);

  localparam int unsigned CNT_W   = $clog2(MAX_BYTES_PER_TRANSACTION + 1);
  localparam int unsigned QUARTER = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);
  localparam int unsigned DIV_W   = $clog2(QUARTER);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WRITE_BYTE, S_WRITE_ACK,
    S_READ_BYTE, S_READ_ACK, S_STOP, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [1:0]         qtr_q, qtr_d;
  logic [2:0]         bit_q, bit_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rd_q, rd_d;
  logic [6:0]         addr_q, addr_d;
  logic [7:0]         din_q  [0:MAX_BYTES_PER_TRANSACTION-1];
  logic [7:0]         din_d  [0:MAX_BYTES_PER_TRANSACTION-1];
  logic [7:0]         dout_q [0:MAX_BYTES_PER_TRANSACTION-1];
  logic [7:0]         dout_d [0:MAX_BYTES_PER_TRANSACTION-1];
  logic [6:0]         shift_q, shift_d;
  logic               samp_q, samp_d;
  logic               ack_err_q, ack_err_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               scl_oe_q, scl_oe_d;
  logic               sda_oe_q, sda_oe_d;
  logic               tick_c;
  logic               slot_end_c;
  logic               slot_scl_c;
  logic               stretch_c;
  logic [7:0]         tx_byte_c;

`ifdef I2C_CLOCK_STRETCH_EN
  // Hold the divider at the start of the SCL-high quarter until the line is actually high.
  assign stretch_c = (qtr_q == 2'd1) && (div_q == '0) && !scl_i &&
                     (state_q inside {S_ADDR, S_ADDR_ACK, S_WRITE_BYTE, S_WRITE_ACK,
                                      S_READ_BYTE, S_READ_ACK, S_STOP});
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign stretch_c  = 1'b0;
`endif

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    qtr_d      = qtr_q;
    bit_d      = bit_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    din_d      = din_q;
    dout_d     = dout_q;
    shift_d    = shift_q;
    samp_d     = samp_q;
    ack_err_d  = ack_err_q;
    tick_c     = 1'b0;
    slot_end_c = 1'b0;
    slot_scl_c = 1'b0;
    tx_byte_c  = 8'h00;
    scl_oe_d   = 1'b0;
    sda_oe_d   = 1'b0;
    done_d     = 1'b0;
    busy_d     = 1'b0;

    // Quarter-period divider, only running while a transaction is on the bus.
    if (state_q != S_IDLE && state_q != S_DONE && !stretch_c) begin
      if (div_q == DIV_W'(QUARTER - 1)) begin
        tick_c = 1'b1;
        div_d  = '0;
        qtr_d  = qtr_q + 2'd1;
      end else begin
        div_d  = div_q + DIV_W'(1);
      end
    end
    slot_end_c = tick_c && (qtr_q == 2'd3);

    // SDA sampled at the Q1/Q2 boundary; read bits land in dout on the 8th sample.
    if (tick_c && (qtr_q == 2'd1)) begin
      samp_d = sda_i;
      if (state_q == S_READ_BYTE) begin
        shift_d = {shift_q[5:0], sda_i};
        if (bit_q == 3'd7) dout_d[idx_q] = {shift_q, sda_i};
      end
    end

    case (state_q)
      S_IDLE: begin
        if (i2c_transaction_start) begin
          rd_d      = i2c_transaction_rd_nwr;
          addr_d    = i2c_transaction_slave_addr;
          din_d     = i2c_master_din;
          cnt_d     = (i2c_transaction_bytes_num > CNT_W'(MAX_BYTES_PER_TRANSACTION)) ?
                      CNT_W'(MAX_BYTES_PER_TRANSACTION) : i2c_transaction_bytes_num;
          div_d     = '0;
          qtr_d     = '0;
          bit_d     = '0;
          idx_d     = '0;
          ack_err_d = 1'b0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (slot_end_c) begin
          bit_d   = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR, S_WRITE_BYTE, S_READ_BYTE: begin
        if (slot_end_c) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            unique case (state_q)
              S_ADDR:       state_d = S_ADDR_ACK;
              S_WRITE_BYTE: state_d = S_WRITE_ACK;
              default:      state_d = S_READ_ACK;
            endcase
          end
        end
      end
      S_ADDR_ACK: begin
        if (slot_end_c) begin
          if (samp_q) begin
            ack_err_d = 1'b1;
            state_d   = S_STOP;
          end else if (cnt_q == '0) begin
            state_d   = S_STOP;
          end else if (rd_q) begin
            state_d   = S_READ_BYTE;
          end else begin
            state_d   = S_WRITE_BYTE;
          end
        end
      end
      S_WRITE_ACK: begin
        if (slot_end_c) begin
          if (samp_q) begin
            ack_err_d = 1'b1;
            state_d   = S_STOP;
          end else begin
            idx_d   = idx_q + CNT_W'(1);
            state_d = ((idx_q + CNT_W'(1)) == cnt_q) ? S_STOP : S_WRITE_BYTE;
          end
        end
      end
      S_READ_ACK: begin
        if (slot_end_c) begin
          idx_d   = idx_q + CNT_W'(1);
          state_d = ((idx_q + CNT_W'(1)) == cnt_q) ? S_STOP : S_READ_BYTE;
        end
      end
      S_STOP: begin
        if (tick_c && (qtr_q == 2'd2)) begin
          qtr_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Line drive for the position being entered, so the pins change with the state.
    slot_scl_c = (qtr_d == 2'd0) || (qtr_d == 2'd3);
    case (state_d)
      S_START: begin
        sda_oe_d = qtr_d[1];
        scl_oe_d = (qtr_d == 2'd3);
      end
      S_ADDR: begin
        tx_byte_c = {addr_d, rd_d};
        scl_oe_d  = slot_scl_c;
        sda_oe_d  = ~tx_byte_c[3'd7 - bit_d];
      end
      S_WRITE_BYTE: begin
        tx_byte_c = din_d[idx_d];
        scl_oe_d  = slot_scl_c;
        sda_oe_d  = ~tx_byte_c[3'd7 - bit_d];
      end
      S_ADDR_ACK, S_WRITE_ACK, S_READ_BYTE: begin
        scl_oe_d = slot_scl_c;
      end
      S_READ_ACK: begin
        scl_oe_d = slot_scl_c;
        sda_oe_d = ((idx_d + CNT_W'(1)) < cnt_d);
      end
      S_STOP: begin
        scl_oe_d = (qtr_d == 2'd0);
        sda_oe_d = (qtr_d != 2'd2);
      end
      default: begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
      end
    endcase
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // State and output registers; reset releases both lines immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      qtr_q     <= '0;
      bit_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '{default: '0};
      dout_q    <= '{default: '0};
      shift_q   <= '0;
      samp_q    <= 1'b1;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      dout_q    <= dout_d;
      shift_q   <= shift_d;
      samp_q    <= samp_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  assign i2c_master_dout           = dout_q;
  assign i2c_transaction_done      = done_q;
  assign i2c_transaction_busy      = busy_q;
  assign i2c_transaction_ack_error = ack_err_q;
  assign scl_oe                    = scl_oe_q;
  assign sda_oe                    = sda_oe_q;

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed bench for i2c_master with a behavioural I2C slave at 0x48.
module tb_i2c_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       rd_nwr;
  logic [6:0] addr;
  logic [1:0] bytes_num;
  logic [7:0] din  [0:2];
  logic [7:0] dout [0:2];
  logic       done, busy, ack_error;
  logic       scl_oe, sda_oe;
  logic       scl_line, sda_line;
  logic       s_sda_oe = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign scl_line = ~scl_oe;
  assign sda_line = ~(sda_oe | s_sda_oe);

  i2c_master #(
    .MAX_BYTES_PER_TRANSACTION(3),
    .CLK_FREQ_HZ(4_000_000),
    .I2C_FREQ_HZ(100_000)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .i2c_transaction_start(start),
    .i2c_transaction_rd_nwr(rd_nwr),
    .i2c_transaction_slave_addr(addr),
    .i2c_transaction_bytes_num(bytes_num),
    .i2c_master_din(din),
    .i2c_master_dout(dout),
    .i2c_transaction_done(done),
    .i2c_transaction_busy(busy),
    .i2c_transaction_ack_error(ack_error),
    .scl_i(scl_line),
    .scl_oe(scl_oe),
    .sda_i(sda_line),
    .sda_oe(sda_oe)
  );

  // Slave model state and logs (written only by the slave process).
  logic [7:0] rdata [0:3] = '{8'h12, 8'h34, 8'h56, 8'h78};
  logic [7:0] rx    [0:7];
  logic       mack  [0:7];
  int         nrx = 0, nmack = 0, rises = 0, start_cnt = 0, stop_cnt = 0;
  int         sbit = 0, sframe = 0;
  logic [7:0] sh = 8'h00;
  logic [7:0] cur = 8'h00;
  bit         first = 0, in_txn = 0, match = 0, rd_mode = 0, sdrive = 0, last_mack = 0;
  bit         scl_p = 1, msda_p = 1;

  // Behavioural slave: samples the bus on every falling clk edge.
  always @(negedge clk) begin : slave
    logic scl_n, msda_n, sda_n;
    scl_n  = ~scl_oe;
    msda_n = ~sda_oe;
    sda_n  = ~(sda_oe | s_sda_oe);
    if (!rst_n) begin
      in_txn = 0; s_sda_oe = 1'b0; sdrive = 0;
    end else if (scl_n && scl_p && msda_p && !msda_n) begin
      in_txn = 1; first = 1; sbit = 0; sframe = 0; nrx = 0; nmack = 0; rises = 0;
      rd_mode = 0; match = 0; sdrive = 0; s_sda_oe = 1'b0; start_cnt++;
    end else if (scl_n && scl_p && !msda_p && msda_n) begin
      in_txn = 0; s_sda_oe = 1'b0; sdrive = 0; stop_cnt++;
    end else if (in_txn && scl_n && !scl_p) begin
      rises++;
      if (sbit < 8 && (sframe == 0 || !rd_mode)) sh = {sh[6:0], sda_n};
      if (sbit == 8 && sframe > 0 && rd_mode) begin
        if (nmack < 8) mack[3'(nmack)] = sda_n;
        nmack++;
        last_mack = sda_n;
      end
    end else if (in_txn && !scl_n && scl_p) begin
      if (first) begin
        first = 0;
      end else begin
        sbit++;
        if (sbit == 8) begin
          sdrive = 0;
          if (sframe == 0) begin
            if (nrx < 8) rx[3'(nrx)] = sh;
            nrx++;
            match = (sh[7:1] == 7'h48);
            rd_mode = sh[0];
            s_sda_oe = match;
          end else if (!rd_mode) begin
            if (nrx < 8) rx[3'(nrx)] = sh;
            nrx++;
            s_sda_oe = match;
          end else begin
            s_sda_oe = 1'b0;
          end
        end else if (sbit == 9) begin
          sbit = 0;
          sframe++;
          sdrive = match && rd_mode && (sframe == 1 || !last_mack) && (sframe <= 4);
          if (sdrive) begin
            cur = rdata[2'(sframe - 1)];
            s_sda_oe = ~cur[7];
          end else begin
            s_sda_oe = 1'b0;
          end
        end else if (sdrive) begin
          cur = rdata[2'(sframe - 1)];
          s_sda_oe = ~cur[3'(7 - sbit)];
        end
      end
    end
    scl_p  = scl_n;
    msda_p = msda_n;
  end

  // Issue one request and wait (bounded) for done; returns at the done cycle.
  task automatic do_txn(input logic [6:0] a, input logic rd, input logic [1:0] n,
                        input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                        output int cyc, output bit to);
    @(negedge clk);
    addr = a; rd_nwr = rd; bytes_num = n;
    din[0] = d0; din[1] = d1; din[2] = d2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    to  = 0;
    while (done !== 1'b1 && !to) begin
      @(negedge clk);
      cyc++;
      if (cyc > 5000) to = 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rd_nwr = 1'b0; addr = '0; bytes_num = '0;
    din[0] = '0; din[1] = '0; din[2] = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({scl_oe, sda_oe, done, busy, ack_error} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got scl_oe,sda_oe,done,busy,ack=%b expected 00000",
               {scl_oe, sda_oe, done, busy, ack_error});
    end
    n_cmp++;
    if ({dout[0], dout[1], dout[2]} !== 24'h0) begin
      n_err++;
      $display("FAIL reset_dout: got %h expected 000000", {dout[0], dout[1], dout[2]});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({scl_oe, sda_oe, busy} !== 3'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got scl_oe,sda_oe,busy=%b expected 000", {scl_oe, sda_oe, busy});
    end
  endtask

  task automatic test_write();
    int cyc; bit to; int stops;
    stops = stop_cnt;
    do_txn(7'h48, 1'b0, 2'd2, 8'hA5, 8'h0F, 8'h00, cyc, to);
    n_cmp++;
    if (to || cyc < 1149 || cyc > 1151) begin
      n_err++;
      $display("FAIL write_latency: got %0d cycles (timeout=%0d) expected 1150+/-1", cyc, to);
    end
    n_cmp++;
    if (ack_error !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL write_status: got ack_error=%b busy=%b expected 0 0", ack_error, busy);
    end
    n_cmp++;
    if (nrx != 3 || rx[0] !== 8'h90 || rx[1] !== 8'hA5 || rx[2] !== 8'h0F) begin
      n_err++;
      $display("FAIL write_wire: got n=%0d %h %h %h expected 3 90 a5 0f", nrx, rx[0], rx[1], rx[2]);
    end
    n_cmp++;
    if ({dout[0], dout[1], dout[2]} !== 24'h0) begin
      n_err++;
      $display("FAIL write_dout: got %h expected 000000", {dout[0], dout[1], dout[2]});
    end
    n_cmp++;
    if (stop_cnt - stops != 1 || rises != 28) begin
      n_err++;
      $display("FAIL write_bus: got stops=%0d scl_rises=%0d expected 1 28", stop_cnt - stops, rises);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL write_done_pulse: got done=%b one cycle later expected 0", done);
    end
  endtask

  task automatic test_read();
    int cyc; bit to;
    do_txn(7'h48, 1'b1, 2'd3, 8'h00, 8'h00, 8'h00, cyc, to);
    n_cmp++;
    if (to || cyc < 1509 || cyc > 1511) begin
      n_err++;
      $display("FAIL read_latency: got %0d cycles (timeout=%0d) expected 1510+/-1", cyc, to);
    end
    n_cmp++;
    if ({dout[0], dout[1], dout[2]} !== 24'h123456) begin
      n_err++;
      $display("FAIL read_dout: got %h expected 123456", {dout[0], dout[1], dout[2]});
    end
    n_cmp++;
    if (nrx != 1 || rx[0] !== 8'h91) begin
      n_err++;
      $display("FAIL read_addr_byte: got n=%0d %h expected 1 91", nrx, rx[0]);
    end
    n_cmp++;
    if (nmack != 3 || {mack[0], mack[1], mack[2]} !== 3'b001) begin
      n_err++;
      $display("FAIL read_master_ack: got n=%0d %b expected 3 001", nmack, {mack[0], mack[1], mack[2]});
    end
    n_cmp++;
    if (ack_error !== 1'b0 || rises != 37) begin
      n_err++;
      $display("FAIL read_status: got ack_error=%b scl_rises=%0d expected 0 37", ack_error, rises);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL read_done_pulse: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_nack();
    int cyc; bit to; int stops;
    stops = stop_cnt;
    do_txn(7'h22, 1'b0, 2'd2, 8'h11, 8'h22, 8'h33, cyc, to);
    n_cmp++;
    if (to || ack_error !== 1'b1) begin
      n_err++;
      $display("FAIL nack_ack_error: got ack_error=%b timeout=%0d expected 1 0", ack_error, to);
    end
    n_cmp++;
    if (nrx != 1 || rx[0] !== 8'h44 || rises != 10 || stop_cnt - stops != 1) begin
      n_err++;
      $display("FAIL nack_bus: got n=%0d addr=%h rises=%0d stops=%0d expected 1 44 10 1",
               nrx, rx[0], rises, stop_cnt - stops);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || ack_error !== 1'b1) begin
      n_err++;
      $display("FAIL nack_after: got busy=%b ack_error=%b expected 0 1", busy, ack_error);
    end
  endtask

  task automatic test_probe();
    int cyc; bit to; int stops;
    stops = stop_cnt;
    do_txn(7'h48, 1'b0, 2'd0, 8'hFF, 8'hFF, 8'hFF, cyc, to);
    n_cmp++;
    if (to || ack_error !== 1'b0 || cyc < 429 || cyc > 431) begin
      n_err++;
      $display("FAIL probe_status: got ack_error=%b cycles=%0d timeout=%0d expected 0 430 0",
               ack_error, cyc, to);
    end
    n_cmp++;
    if (nrx != 1 || rx[0] !== 8'h90 || rises != 10 || stop_cnt - stops != 1) begin
      n_err++;
      $display("FAIL probe_bus: got n=%0d addr=%h rises=%0d stops=%0d expected 1 90 10 1",
               nrx, rx[0], rises, stop_cnt - stops);
    end
  endtask

  task automatic test_reset_mid();
    int cyc; bit to;
    @(negedge clk);
    addr = 7'h48; rd_nwr = 1'b1; bytes_num = 2'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (445) @(negedge clk);
    n_cmp++;
    if (scl_oe !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_read_pre: got scl_oe=%b busy=%b expected 1 1", scl_oe, busy);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({scl_oe, sda_oe, busy, done} !== 4'b0) begin
      n_err++;
      $display("FAIL async_reset: got scl_oe,sda_oe,busy,done=%b expected 0000", {scl_oe, sda_oe, busy, done});
    end
    n_cmp++;
    if ({dout[0], dout[1], dout[2]} !== 24'h0) begin
      n_err++;
      $display("FAIL async_reset_dout: got %h expected 000000", {dout[0], dout[1], dout[2]});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    do_txn(7'h48, 1'b1, 2'd2, 8'h00, 8'h00, 8'h00, cyc, to);
    n_cmp++;
    if (to || {dout[0], dout[1], dout[2]} !== 24'h123400) begin
      n_err++;
      $display("FAIL post_reset_read: got %h timeout=%0d expected 123400 0", {dout[0], dout[1], dout[2]}, to);
    end
    n_cmp++;
    if (nmack != 2 || {mack[0], mack[1]} !== 2'b01 || ack_error !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_acks: got n=%0d %b ack_error=%b expected 2 01 0",
               nmack, {mack[0], mack[1]}, ack_error);
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit to; int starts; bit seen;
    @(negedge clk);
    starts = start_cnt;
    addr = 7'h48; rd_nwr = 1'b0; bytes_num = 2'd1;
    din[0] = 8'hA5; din[1] = 8'h00; din[2] = 8'h00;
    start = 1'b1;
    cyc = 0; to = 0;
    while (done !== 1'b1 && !to) begin
      @(negedge clk); cyc++;
      if (cyc > 5000) to = 1;
    end
    n_cmp++;
    if (to || busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_first_done: got busy=%b timeout=%0d expected 0 0", busy, to);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_done_cycle_ignored: got done=%b busy=%b expected 0 0", done, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_second_accept: got busy=%b expected 1", busy);
    end
    start = 1'b0;
    repeat (200) @(negedge clk);
    addr = 7'h22; rd_nwr = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; to = 0;
    while (done !== 1'b1 && !to) begin
      @(negedge clk); cyc++;
      if (cyc > 5000) to = 1;
    end
    n_cmp++;
    if (to || ack_error !== 1'b0 || nrx != 2 || rx[0] !== 8'h90 || rx[1] !== 8'hA5) begin
      n_err++;
      $display("FAIL b2b_second_txn: got ack_error=%b n=%0d %h %h timeout=%0d expected 0 2 90 a5 0",
               ack_error, nrx, rx[0], rx[1], to);
    end
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy === 1'b1) seen = 1;
    end
    n_cmp++;
    if (seen || start_cnt - starts != 2) begin
      n_err++;
      $display("FAIL b2b_exactly_two: got extra_busy=%0d starts=%0d expected 0 2", seen, start_cnt - starts);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_probe();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
